// File: rtl/e203_axi_arb_ctrl.sv
// Round-robin arbiter that lets NUM_MST AXI masters share one slave, one transaction at a time.
// Define E203_AXI_ARB_TIMEOUT_EN to build in the per-transaction watchdog (to_err).
module e203_axi_arb_ctrl #(
    parameter int unsigned NUM_MST  = 4,
    parameter int unsigned TO_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] mst_arvalid,
    input  logic [NUM_MST-1:0] mst_awvalid,
    input  logic               slv_arready,
    input  logic               slv_awready,
    input  logic               slv_rvalid,
    input  logic               slv_rready,
    input  logic               slv_rlast,
    input  logic               slv_bvalid,
    input  logic               slv_bready,
    output logic [NUM_MST-1:0] gnt,
    output logic               gnt_wr,
    output logic               arb_busy,
    output logic               to_err
);

    localparam int unsigned IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        WRESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_MST-1:0] gnt_q, gnt_d;
    logic               gnt_wr_q, gnt_wr_d;
    logic               busy_q, busy_d;
    logic               to_err_q, to_err_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NUM_MST-1:0] req_c;
    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    int unsigned        cand_c;
    logic               addr_hs_c;
    logic               cmpl_c;

`ifdef E203_AXI_ARB_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
    logic               tmo_c;
`endif

    // Round-robin search starting just above the last served master.
    always_comb begin
        req_c       = mst_arvalid | mst_awvalid;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = 0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            cand_c = (32'(ptr_q) + k) % NUM_MST;
            if (!win_found_c && req_c[IDX_W'(cand_c)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(cand_c);
            end
        end
    end

    always_comb begin
        addr_hs_c = gnt_wr_q ? ((|(mst_awvalid & gnt_q)) & slv_awready)
                             : ((|(mst_arvalid & gnt_q)) & slv_arready);
        cmpl_c    = ((state_q == RDATA) && slv_rvalid && slv_rready && slv_rlast) ||
                    ((state_q == WRESP) && slv_bvalid && slv_bready);
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_wr_d = gnt_wr_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        to_err_d = 1'b0;
`ifdef E203_AXI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_c    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d  = ADDR;
                    gnt_d    = NUM_MST'(1) << win_idx_c;
                    gnt_wr_d = ~mst_arvalid[win_idx_c];
                    idx_d    = win_idx_c;
                end
            end
            ADDR: begin
                if (addr_hs_c) begin
                    state_d = gnt_wr_q ? WRESP : RDATA;
                end
            end
            default: ;
        endcase

`ifdef E203_AXI_ARB_TIMEOUT_EN
        // Saturating watchdog; any exit taken this cycle beats the timeout.
        if (state_q == IDLE) begin
            if (win_found_c) begin
                cnt_d = '0;
            end
        end else begin
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            tmo_c = (cnt_q >= 8'(TO_LIMIT)) && !cmpl_c &&
                    !((state_q == ADDR) && addr_hs_c);
        end
        if (tmo_c) begin
            to_err_d = 1'b1;
        end
`endif

        if (cmpl_c
`ifdef E203_AXI_ARB_TIMEOUT_EN
            || tmo_c
`endif
        ) begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_wr_d = 1'b0;
            ptr_d    = idx_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
            ptr_q    <= IDX_W'(NUM_MST - 1);
            idx_q    <= '0;
`ifdef E203_AXI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_wr_q <= gnt_wr_d;
            busy_q   <= busy_d;
            to_err_q <= to_err_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
`ifdef E203_AXI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign gnt_wr   = gnt_wr_q;
    assign arb_busy = busy_q;
    assign to_err   = to_err_q;

endmodule

// File: tb/tb_e203_axi_arb_ctrl.sv
// Bench for e203_axi_arb_ctrl: directed scenarios plus randomized transactions
// predicted by a transaction-level round-robin model.
module tb_e203_axi_arb_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] mst_arvalid;
    logic [N-1:0] mst_awvalid;
    logic         slv_arready, slv_awready;
    logic         slv_rvalid, slv_rready, slv_rlast;
    logic         slv_bvalid, slv_bready;
    logic [N-1:0] gnt;
    logic         gnt_wr;
    logic         arb_busy;
    logic         to_err;

    int checks = 0;
    int errors = 0;
    int m_ptr  = N - 1;

    e203_axi_arb_ctrl #(.NUM_MST(N), .TO_LIMIT(TO)) dut (
        .clk(clk), .rst(rst),
        .mst_arvalid(mst_arvalid), .mst_awvalid(mst_awvalid),
        .slv_arready(slv_arready), .slv_awready(slv_awready),
        .slv_rvalid(slv_rvalid), .slv_rready(slv_rready), .slv_rlast(slv_rlast),
        .slv_bvalid(slv_bvalid), .slv_bready(slv_bready),
        .gnt(gnt), .gnt_wr(gnt_wr), .arb_busy(arb_busy), .to_err(to_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_slave();
        slv_arready = 1'b0; slv_awready = 1'b0;
        slv_rvalid  = 1'b0; slv_rready  = 1'b0; slv_rlast = 1'b0;
        slv_bvalid  = 1'b0; slv_bready  = 1'b0;
    endtask

    // Model: first requester found scanning upward from the last served master, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (req[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic check_held(input string tag, input int w, input bit wr);
        check(tag, 32'(gnt), 32'(1) << w);
        check({tag, "_wr"}, 32'(gnt_wr), 32'(wr));
    endtask

    // One complete transaction using the requests currently driven; nxt_* is driven
    // in the completion cycle so the following grant can be checked for the idle gap.
    task automatic run_txn(input logic [N-1:0] nxt_ar, input logic [N-1:0] nxt_aw, input int beats);
        int w;
        bit wr;
        int n;
        w = rr_pick(mst_arvalid | mst_awvalid, m_ptr);
        if (w < 0) begin
            tick();
            check("no_req_no_gnt", 32'(gnt), 0);
            check("no_req_idle", 32'(arb_busy), 0);
            mst_arvalid = nxt_ar;
            mst_awvalid = nxt_aw;
            return;
        end
        wr = !mst_arvalid[2'(w)];
        tick();
        check_held("grant", w, wr);
        check("grant_busy", 32'(arb_busy), 1);

        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            mst_arvalid = 4'($urandom);
            mst_awvalid = 4'($urandom);
            slv_arready = wr ? 1'($urandom) : 1'b0;
            slv_awready = wr ? 1'b0 : 1'($urandom);
            tick();
            check_held("addr_hold", w, wr);
        end
        mst_arvalid = 4'($urandom);
        mst_awvalid = 4'($urandom);
        if (wr) mst_awvalid[2'(w)] = 1'b1;
        else    mst_arvalid[2'(w)] = 1'b1;
        slv_arready = 1'b1;
        slv_awready = 1'b1;
        tick();
        check_held("addr_done", w, wr);
        slv_arready = 1'b0;
        slv_awready = 1'b0;
        mst_arvalid = 4'($urandom);
        mst_awvalid = 4'($urandom);

        if (!wr) begin
            for (int b = 0; b < beats; b++) begin
                n = $urandom_range(0, 1);
                for (int g = 0; g < n; g++) begin
                    slv_rvalid = 1'($urandom);
                    slv_rlast  = 1'($urandom);
                    slv_rready = (slv_rvalid && slv_rlast) ? 1'b0 : 1'($urandom);
                    slv_bvalid = 1'b1;
                    slv_bready = 1'b1;
                    tick();
                    check_held("rdata_gap", w, wr);
                end
                slv_bvalid = 1'b0; slv_bready = 1'b0;
                slv_rvalid = 1'b1; slv_rready = 1'b1;
                slv_rlast  = (b == beats - 1);
                if (b == beats - 1) begin
                    mst_arvalid = nxt_ar;
                    mst_awvalid = nxt_aw;
                end
                tick();
                if (b != beats - 1) check_held("rdata_beat", w, wr);
            end
        end else begin
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) begin
                slv_bvalid = 1'($urandom);
                slv_bready = slv_bvalid ? 1'b0 : 1'($urandom);
                slv_rvalid = 1'b1; slv_rready = 1'b1; slv_rlast = 1'b1;
                tick();
                check_held("wresp_wait", w, wr);
            end
            slv_rvalid = 1'b0; slv_rready = 1'b0; slv_rlast = 1'b0;
            slv_bvalid = 1'b1; slv_bready = 1'b1;
            mst_arvalid = nxt_ar;
            mst_awvalid = nxt_aw;
            tick();
        end
        check("release_gnt", 32'(gnt), 0);
        check("release_wr", 32'(gnt_wr), 0);
        check("release_busy", 32'(arb_busy), 0);
        check("release_to_err", 32'(to_err), 0);
        m_ptr = w;
        quiet_slave();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        mst_arvalid = 4'hF;
        mst_awvalid = 4'h0;
        quiet_slave();
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_gnt_wr", 32'(gnt_wr), 0);
        check("rst_busy", 32'(arb_busy), 0);
        check("rst_to_err", 32'(to_err), 0);
        mst_arvalid = 4'h0;
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(gnt), 0);

        // Single read by master 2, four beats.
        mst_arvalid = 4'b0100;
        run_txn(4'h0, 4'h0, 4);
        check("single_read_ptr", 32'(m_ptr), 2);

        // All masters reading continuously.
        mst_arvalid = 4'hF;
        for (int i = 0; i < 5; i++) run_txn(4'hF, 4'h0, 1);
        mst_arvalid = 4'h0;
        run_txn(4'h0, 4'h0, 1);

        // Same master asks read and write: read first, then the write.
        mst_arvalid = 4'b0010;
        mst_awvalid = 4'b0010;
        run_txn(4'h0, 4'b0010, 2);
        run_txn(4'h0, 4'h0, 1);

        // New request rising in the completion cycle.
        mst_arvalid = 4'b0001;
        run_txn(4'b0100, 4'h0, 2);
        run_txn(4'h0, 4'h0, 2);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            run_txn(4'($urandom), 4'($urandom & $urandom), $urandom_range(1, 4));
        end
        mst_arvalid = 4'h0;
        mst_awvalid = 4'h0;
        tick();
        tick();
        check("rand_drain", 32'(gnt), 0);

        // Stalled write response from master 3.
        mst_awvalid = 4'b1000;
        tick();
        check_held("stall_grant", 3, 1'b1);
        slv_awready = 1'b1;
        tick();
        slv_awready = 1'b0;
        mst_awvalid = 4'h0;
`ifdef E203_AXI_ARB_TIMEOUT_EN
        for (int k = 2; k <= int'(TO); k++) begin
            tick();
            check("to_wait_err", 32'(to_err), 0);
            check_held("to_wait_gnt", 3, 1'b1);
        end
        tick();
        check("to_pulse", 32'(to_err), 1);
        check("to_gnt_clear", 32'(gnt), 0);
        tick();
        check("to_pulse_end", 32'(to_err), 0);
        m_ptr = 3;
`else
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k % 25 == 24) begin
                check("stall_to_err", 32'(to_err), 0);
                check_held("stall_gnt", 3, 1'b1);
            end
        end
        slv_bvalid = 1'b1;
        slv_bready = 1'b1;
        tick();
        quiet_slave();
        check("stall_release", 32'(gnt), 0);
        m_ptr = 3;
`endif
        mst_arvalid = 4'b0001;
        mst_awvalid = 4'b0001;
        run_txn(4'h0, 4'h0, 1);

        // Reset during the second read beat.
        mst_arvalid = 4'b0100;
        tick();
        check_held("mid_rst_grant", 2, 1'b0);
        slv_arready = 1'b1;
        tick();
        slv_arready = 1'b0;
        slv_rvalid = 1'b1; slv_rready = 1'b1; slv_rlast = 1'b0;
        tick();
        check_held("mid_rst_beat1", 2, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_async_gnt", 32'(gnt), 0);
        check("mid_rst_async_busy", 32'(arb_busy), 0);
        tick();
        rst = 1'b0;
        quiet_slave();
        m_ptr = N - 1;
        mst_arvalid = 4'hF;
        tick();
        check_held("after_rst_first", 0, 1'b0);
        check("after_rst_model", 32'(rr_pick(4'hF, m_ptr)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_axi_arb_ctrl.md
E203_AXI_ARB_CTRL -- requirements
Module: e203_axi_arb_ctrl

Interface
REQ-001 Parameter NUM_MST, default 4: number of AXI masters sharing the single AXI slave port.
REQ-002 Parameter TO_LIMIT, default 255: timeout threshold in cycles, 8-bit range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mst_arvalid  input  NUM_MST  per-master read-address request.
REQ-006 mst_awvalid  input  NUM_MST  per-master write-address request.
REQ-007 slv_arready  input  1  slave AR ready.
REQ-008 slv_awready  input  1  slave AW ready.
REQ-009 slv_rvalid, slv_rready, slv_rlast  input  1 each  slave R-channel handshake and last beat.
REQ-010 slv_bvalid, slv_bready  input  1 each  slave B-channel handshake.
REQ-011 gnt  output  NUM_MST  one-hot grant, registered; drives the external channel mux.
REQ-012 gnt_wr  output  1  1 = the granted transaction is a write, 0 = a read.
REQ-013 arb_busy  output  1  high in any state other than IDLE.
REQ-014 to_err  output  1  one-cycle timeout pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, ADDR, RDATA and WRESP.
REQ-016 IDLE SHALL apply when any master has mst_arvalid|mst_awvalid set.
  - Select a winner round-robin, searching from index ptr+1 upward with wrap.
  - Register gnt, gnt_wr and state ADDR, so gnt rises exactly one cycle after the request is first sampled.
REQ-017 If the winner asserts both arvalid and awvalid, read SHALL win (gnt_wr=0); the write is served in a later round.
REQ-018 ADDR SHALL exit on the address handshake of the granted master.
  - Read: mst_arvalid[i] & slv_arready moves to RDATA.
  - Write: mst_awvalid[i] & slv_awready moves to WRESP.
  - Otherwise hold with gnt stable.
REQ-019 RDATA SHALL exit on slv_rvalid & slv_rready & slv_rlast: move to IDLE, gnt cleared next cycle, ptr <= granted index.
REQ-020 WRESP SHALL exit on slv_bvalid & slv_bready: move to IDLE, gnt cleared next cycle, ptr <= granted index.
REQ-021 gnt, gnt_wr SHALL remain constant from ADDR entry through RDATA/WRESP exit; a granted master deasserting its valid in ADDR does not release the grant.
REQ-022 At most one transaction SHALL be outstanding; at least one IDLE cycle with gnt=0 separates consecutive grants.
REQ-023 Requests arriving in non-IDLE states SHALL be ignored until IDLE; requests in IDLE are sampled that cycle.
REQ-024 ptr SHALL update only on normal completion (REQ-019/020) or timeout (REQ-030).

Reset
REQ-025 While rst=1 the block SHALL be held in reset.
  - Outputs: state=IDLE, gnt=0, gnt_wr=0, arb_busy=0, to_err=0.
  - ptr=NUM_MST-1, so master 0 has first priority.
  - Timeout counter=0.
REQ-026 Reset assertion mid-transaction SHALL drop gnt asynchronously; no completion is recorded.
REQ-027 After rst deasserts, the first arbitration SHALL occur on the first clk edge with a request present.

Configuration
REQ-028 Macro E203_AXI_ARB_TIMEOUT_EN SHALL compile the transaction watchdog in or out.
REQ-029 With the macro defined, an 8-bit counter SHALL clear on IDLE->ADDR and increment each cycle in ADDR/RDATA/WRESP.
REQ-030 With the macro defined, when the counter equals TO_LIMIT and no exit condition is met that cycle:
  - to_err pulses 1 cycle.
  - FSM goes to IDLE; gnt clears next cycle.
  - ptr <= granted index.
REQ-031 A normal exit in the same cycle as the timeout SHALL take precedence, with no to_err.
REQ-032 Without the macro, no counter SHALL exist, to_err is tied 0, and the FSM waits indefinitely.

Verification
REQ-033 Single read: arvalid=4'b0100 in IDLE -> next cycle gnt=0100, gnt_wr=0; arready handshake, then 4 R beats with rlast on the 4th -> gnt=0 next cycle, ptr=2.
REQ-034 Round-robin: all four masters hold arvalid continuously after reset, each read completes in 3 cycles -> grant order 0,1,2,3,0 with one gnt=0 cycle between grants.
REQ-035 Same-master read/write conflict:
  - Master 1 asserts arvalid and awvalid -> read granted first (gnt_wr=0).
  - After completion, master 1 only requesting -> next grant gnt=0010, gnt_wr=1; completes on B handshake.
REQ-036 Timeout (macro on, TO_LIMIT=10): grant master 3 write, withhold slv_bvalid -> to_err=1 for exactly one cycle 10 cycles after ADDR entry, then gnt=0.
  - Same stimulus with the macro off -> gnt held indefinitely and to_err stays 0.
REQ-037 Reset mid-read: assert rst during RDATA beat 2 -> gnt=0 immediately; after release, arvalid=1111 -> master 0 granted first.
REQ-038 Simultaneous events: rlast handshake in the same cycle a new arvalid rises on another master -> no grant that cycle; grant follows after exactly one IDLE cycle.
